branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
// - EX-side counterpart to the IF-stage BTB. Holds one in-flight prediction record per fetched instruction.
// - Resolves each record against the actual EX outcome and issues redirect/flush on a mispredict.
// - Drives the BTB write port (pc, target) for every resolved jal/jalr/taken br.
// PARAMETERS
// - DEPTH    4   in-flight prediction entries; power of 2, >=2
// - PTR_W    $clog2(DEPTH)   derived; do not override
// PORTS
// clk             in   1   clock
// rst             in   1   synchronous, active-high reset
// if_valid        in   1   IF fetched an instruction this cycle
// if_pc           in   32  PC of fetched instruction
// if_pred_hit     in   1   BTB hit for if_pc
// if_pred_target  in   32  BTB target for if_pc; ignored if !if_pred_hit
// if_ready        out  1   !full; IF stalls when 0
// ex_valid        in   1   instruction resolving in EX this cycle
// opcode_EX       in   rv32i_opcode  opcode of resolving instruction
// pc_from_EX      in   32  PC of resolving instruction
// br_en           in   1   branch condition (op_br only)
// branch_pc       in   32  computed target (alu_out)
// redirect        out  1   1-cycle pulse: refetch from redirect_pc
// redirect_pc     out  32  correct next PC
// btb_we          out  1   1-cycle pulse: write BTB
// btb_pc          out  32  BTB tag/index PC
// btb_target      out  32  BTB target
// sync_err        out  1   sticky: EX pc != head pc, or pop on empty
// BEHAVIOUR
// - Circular FIFO {pc, pred_next}; pred_next = if_pred_hit ? if_pred_target : if_pc+4 (mod 2^32).
// - Push when if_valid && if_ready; entry visible to EX the next cycle (no IF->EX bypass).
// - Pop when ex_valid && !empty. Every instruction pops, control or not.
// - ex_valid && empty: no pop; set sync_err. Head pc != pc_from_EX: still pop; set sync_err.
// - taken = op_jal | op_jalr | (op_br & br_en); act_next = taken ? branch_pc : pc_from_EX+4.
// - mispredict = pop && (act_next != head.pred_next). Covers BTB false hit on a non-control op.
// - Mispredict, cycle N: all entries cleared (rd=wr=count=0); any push in cycle N dropped.
//   - N+1: redirect=1, redirect_pc=act_next.
// - Resolved jal/jalr/op_br with taken=1: N+1 btb_we=1, btb_pc=pc_from_EX, btb_target=branch_pc.
//   - Not-taken br: no BTB write.
// - Simultaneous push+pop when full: both occur, count unchanged, if_ready stays 0 that cycle.
// - Pointers wrap modulo DEPTH; count is PTR_W+1 bits, 0..DEPTH.
// - Reset, including mid-operation: FIFO empty; if_ready=1.
//   - redirect, redirect_pc, btb_we, btb_pc, btb_target, sync_err all 0.
// - sync_err clears only on rst.
// CONFIGURATION
// - BRU_PERF_CNT_EN defined: adds outputs perf_ctrl_cnt[31:0] and perf_mispred_cnt[31:0].
//   - perf_ctrl_cnt: +1 per popped jal/jalr/br. perf_mispred_cnt: +1 per mispredict.
//   - Both are registered, wrap at 2^32, reset to 0.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - rst; push pc=0x40 hit=0; EX non-ctrl pc=0x40 -> no redirect, no btb_we, FIFO empty.
// - Push 0x100 hit=0; EX op_br 0x100 br_en=1 branch_pc=0x180:
//   - next cycle redirect=1, redirect_pc=0x180; btb_we=1, btb_pc=0x100, btb_target=0x180.
// - Push 0x200 hit=1 tgt=0x300; EX op_jal 0x200 branch_pc=0x300 -> no redirect; btb_we=1.
// - Push 0x10,0x14,0x18 (0x10 hit tgt=0x80); EX op_br 0x10 br_en=0 -> redirect_pc=0x14.
//   - FIFO empty; a push in the mispredict cycle is dropped.
// - Fill DEPTH=4 -> if_ready=0; push+pop same cycle accepted; ex_valid on empty -> sync_err=1 until rst.
// - rst asserted with 3 entries pending -> all outputs 0, if_ready=1; perf counters (if enabled) = 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-side branch resolver: tracks one prediction per fetched instruction, flags mispredicts, and updates the BTB.
// Optional BRU_PERF_CNT_EN adds the control-op and mispredict counters.
package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;
endpackage

module branch_resolve_unit
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        if_pred_hit,
    input  logic [31:0] if_pred_target,
    output logic        if_ready,
    input  logic        ex_valid,
    input  rv32i_opcode opcode_EX,
    input  logic [31:0] pc_from_EX,
    input  logic        br_en,
    input  logic [31:0] branch_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        btb_we,
    output logic [31:0] btb_pc,
    output logic [31:0] btb_target,
    output logic        sync_err
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0] perf_ctrl_cnt,
    output logic [31:0] perf_mispred_cnt
`endif
);
    localparam int CW = PTR_W + 1;

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      pred_mem [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             redirect_q, btb_we_q, sync_err_q;
    logic [31:0]      redirect_pc_q, btb_pc_q, btb_target_q;

    logic        full, empty, push, pop, is_ctrl, taken, mispredict, sync_err_d;
    logic [31:0] act_next, push_pred;

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        pop        = ex_valid && !empty;
        // A full FIFO still accepts a fetch when the head retires in the same cycle.
        push       = if_valid && (!full || pop);
        push_pred  = if_pred_hit ? if_pred_target : (if_pc + 32'd4);
        is_ctrl    = (opcode_EX == op_jal) || (opcode_EX == op_jalr) || (opcode_EX == op_br);
        taken      = (opcode_EX == op_jal) || (opcode_EX == op_jalr) || ((opcode_EX == op_br) && br_en);
        act_next   = taken ? branch_pc : (pc_from_EX + 32'd4);
        mispredict = pop && (act_next != pred_mem[rd_q]);
        sync_err_d = sync_err_q || (ex_valid && empty) || (pop && (pc_mem[rd_q] != pc_from_EX));

        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (mispredict) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push && !mispredict) begin
            pc_mem[wr_q]   <= if_pc;
            pred_mem[wr_q] <= push_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q          <= '0;
            wr_q          <= '0;
            count_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            btb_we_q      <= 1'b0;
            btb_pc_q      <= '0;
            btb_target_q  <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            redirect_q <= mispredict;
            btb_we_q   <= pop && taken;
            sync_err_q <= sync_err_d;
            if (mispredict) redirect_pc_q <= act_next;
            if (pop && taken) begin
                btb_pc_q     <= pc_from_EX;
                btb_target_q <= branch_pc;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_ctrl_q, perf_mispred_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ctrl_q    <= '0;
            perf_mispred_q <= '0;
        end else begin
            if (pop && is_ctrl) perf_ctrl_q    <= perf_ctrl_q + 32'd1;
            if (mispredict)     perf_mispred_q <= perf_mispred_q + 32'd1;
        end
    end
    assign perf_ctrl_cnt    = perf_ctrl_q;
    assign perf_mispred_cnt = perf_mispred_q;
`else
    logic unused_ctrl;
    assign unused_ctrl = is_ctrl;
`endif

    assign if_ready    = !full;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign btb_we      = btb_we_q;
    assign btb_pc      = btb_pc_q;
    assign btb_target  = btb_target_q;
    assign sync_err    = sync_err_q;
endmodule
